// File: rtl/serial_adder_pkg.sv
// Shared types and default sizing for the bit-serial adder sequencer.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_FA_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_timer.sv
// Loadable down-counter: strobe is high in the LATENCY-th cycle after load.
module serial_adder_timer #(
  parameter int LATENCY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic strobe
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples its inputs from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(LATENCY);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign strobe = (count == CW'(1));

endmodule : serial_adder_timer

// File: rtl/serial_adder_sequencer.sv
// Drives an external multi-cycle 1-bit full adder LSB-first to add two words.
// Optional signed overflow flag enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder_sequencer
  import serial_adder_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int FA_LATENCY = DEFAULT_FA_LATENCY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout_out,
  output logic             overflow
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    next_idx;
  logic             sample;
  logic             last_bit;
  logic             sample_now;

  assign next_idx   = idx + 1'b1;
  assign last_bit   = (idx == IW'(WIDTH - 1));
  assign sample_now = (state == WAIT) && sample;

  serial_adder_timer #(
    .LATENCY (FA_LATENCY)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state == ISSUE),
    .strobe (sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      result   <= '0;
      cout_out <= 1'b0;
      fa_a     <= 1'b0;
      fa_b     <= 1'b0;
      fa_cin   <= 1'b0;
    end else begin
      // The adder drive is a one-cycle pulse, loaded on the edge entering ISSUE.
      fa_a   <= 1'b0;
      fa_b   <= 1'b0;
      fa_cin <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= op_a;
            b_q    <= op_b;
            carry  <= cin_in;
            idx    <= '0;
            fa_a   <= op_a[0];
            fa_b   <= op_b[0];
            fa_cin <= cin_in;
            state  <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (sample) begin
            result[idx] <= fa_sum;
            carry       <= fa_cout;
            if (last_bit) begin
              cout_out <= fa_cout;
              state    <= DONE;
            end else begin
              idx    <= next_idx;
              fa_a   <= a_q[next_idx];
              fa_b   <= b_q[next_idx];
              fa_cin <= fa_cout;
              state  <= ISSUE;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic overflow_q;

  // carry still holds the carry into the MSB when the MSB result is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (sample_now && last_bit) begin
      overflow_q <= carry ^ fa_cout;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule : serial_adder_sequencer

// File: tb/tb_serial_adder_sequencer.sv
// Directed bench for serial_adder_sequencer with a pipelined full-adder model.
module tb_serial_adder_sequencer;

  localparam int W = 8;
  localparam int L = 3;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin_in = 1'b0;
  logic         fa_a, fa_b, fa_cin;
  logic         fa_sum, fa_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout_out;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_sequencer #(.WIDTH(W), .FA_LATENCY(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin_in    (cin_in),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_sum    (fa_sum),
    .fa_cout   (fa_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout_out  (cout_out),
    .overflow  (overflow)
  );

  // External full adder: inputs seen in cycle n produce outputs in cycle n+L.
  logic [3*L-1:0] fa_pipe = '0;
  logic           pa, pb, pc;
  always @(posedge clk) fa_pipe <= {fa_pipe[3*L-4:0], fa_a, fa_b, fa_cin};
  assign {pa, pb, pc} = fa_pipe[3*L-1 -: 3];
  assign fa_sum  = pa ^ pb ^ pc;
  assign fa_cout = (pa & pb) | (pa & pc) | (pb & pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accept one operand pair, check every issue pulse and the final result.
  // Leaves the DUT in DONE with out_ready low.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] er, input logic ec, input logic eo);
    logic carry;
    int   idle_bad;
    int   i;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    op_a = a; op_b = b; cin_in = c; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    carry    = c;
    idle_bad = 0;
    for (int k = 0; k < W * (L + 1); k++) begin
      @(negedge clk);
      if (out_valid || in_ready) idle_bad++;
      if (k % (L + 1) == 0) begin
        i = k / (L + 1);
        check($sformatf("%s.issue%0d", tag, i), 32'({fa_a, fa_b, fa_cin}), 32'({a[i], b[i], carry}));
        carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
      end else if ({fa_a, fa_b, fa_cin} != 3'b000) begin
        idle_bad++;
      end
    end
    check({tag, ".busy_idle"}, 32'(idle_bad), 32'd0);
    @(negedge clk);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".result"}, 32'(result), 32'(er));
    check({tag, ".cout"}, 32'(cout_out), 32'(ec));
    check({tag, ".overflow"}, 32'(overflow), 32'(eo));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, ".post_hs"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  initial begin
    int bad;
    #12;
    check("reset.outs", 32'({out_valid, result, cout_out, overflow, fa_a, fa_b, fa_cin}), 32'd0);
    check("reset.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("inc_nibble", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    handshake("inc_nibble");
    run_op("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    handshake("wrap");
    run_op("pos_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF);
    handshake("pos_ovf");
    run_op("neg_ovf", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, OVF);
    handshake("neg_ovf");
    run_op("cin_full", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    handshake("cin_full");
    run_op("cin_mix", 8'h3C, 8'h41, 1'b1, 8'h7E, 1'b0, 1'b0);

    // Back-pressure: DONE must hold everything for as long as out_ready stays low.
    bad = 0;
    op_a = 8'h11; op_b = 8'h22; cin_in = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!out_valid || in_ready || result != 8'h7E || cout_out || overflow ||
          {fa_a, fa_b, fa_cin} != 3'b000) bad++;
    end
    check("stall.hold", 32'(bad), 32'd0);
    in_valid = 1'b0;
    handshake("stall");
    run_op("after_stall", 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, OVF);
    handshake("after_stall");

    // Reset asserted while bit 4 is on the adder.
    @(negedge clk);
    op_a = 8'hAA; op_b = 8'h55; cin_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4 * (L + 1) + 1) @(negedge clk);
    check("abort.bit4", 32'({fa_a, fa_b, fa_cin}), 32'b010);
    rst_n = 1'b0;
    #1;
    check("abort.outs", 32'({out_valid, result, cout_out, overflow, fa_a, fa_b, fa_cin}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("abort.in_ready", 32'(in_ready), 32'd1);
    run_op("fresh", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    handshake("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_adder_sequencer

// File: doc/serial_adder_sequencer.md
SERIAL_ADDER_SEQUENCER -- requirements
Module: serial_adder_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (WIDTH >= 1).
REQ-002 Parameter FA_LATENCY, default 3, clk cycles from driving fa_a/fa_b/fa_cin to valid fa_sum/fa_cout (FA_LATENCY >= 1).
REQ-003 clk  in  1  single clock for all state.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  operand pair offered.
REQ-006 in_ready  out  1  sequencer can accept an operand pair.
REQ-007 op_a, op_b  in  WIDTH  unsigned/two's-complement operands.
REQ-008 cin_in  in  1  carry-in for bit 0.
REQ-009 fa_a, fa_b, fa_cin  out  1 each  bit drive to the 1-bit full adder.
REQ-010 fa_sum, fa_cout  in  1 each  full-adder outputs.
REQ-011 out_valid  out  1  result available.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 result  out  WIDTH  sum; cout_out  out  1  final carry; overflow  out  1  signed overflow.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 IDLE: on in_valid&in_ready at cycle T, register op_a, op_b, set carry register to cin_in, bit index to 0, go to ISSUE.
REQ-016 ISSUE (one cycle): drive fa_a=op_a[idx], fa_b=op_b[idx], fa_cin=carry; go to WAIT; in all other states fa_a/fa_b/fa_cin=0.
REQ-017 WAIT: count FA_LATENCY cycles after the issue cycle; in the FA_LATENCY-th cycle sample fa_sum into result[idx] and fa_cout into carry.
REQ-018 After sampling: if idx==WIDTH-1 go to DONE, else increment idx and go to ISSUE.
REQ-019 Bit i issued at T+1+i*(FA_LATENCY+1); out_valid rises at T+1+WIDTH*(FA_LATENCY+1) (T+33 for defaults).
REQ-020 fa_sum/fa_cout are ignored outside sample cycles.
REQ-021 DONE: result, cout_out, overflow held stable until out_valid&out_ready; then go to IDLE; next operand accepted no earlier than following cycle.
REQ-022 WIDTH=1: single ISSUE/WAIT pass, then DONE.

Reset
REQ-023 rst_n low, at any point including mid-operation: state=IDLE, idx=0, carry=0, result=0, cout_out=0, overflow=0, out_valid=0, fa_a/fa_b/fa_cin=0, in-flight operation discarded.
REQ-024 in_ready=1 in the first cycle after rst_n deasserts; late fa_sum/fa_cout from an aborted operation have no effect.

Configuration
REQ-025 Macro SERIAL_ADDER_OVERFLOW_EN defined: overflow = carry-in of bit WIDTH-1 XOR final carry, registered with result.
REQ-026 Macro undefined: overflow port present, tied to 0, no extra registers.

Structure
REQ-027 Package serial_adder_pkg holds the FSM state typedef and default WIDTH/FA_LATENCY constants.
REQ-028 One sub-module serial_adder_timer: loadable down-counter generating the WAIT sample strobe.

Verification
REQ-029 0x0F+0x01, cin_in=0, accepted at T -> result=0x10, cout_out=0 at T+33.
REQ-030 0xFF+0x01, cin_in=0 -> result=0x00, cout_out=1, overflow=0.
REQ-031 0x7F+0x01 -> result=0x80, overflow=1 with SERIAL_ADDER_OVERFLOW_EN, 0 without.
REQ-032 out_ready low 10 cycles after out_valid -> result stable, in_ready=0, fa_* idle; accept next op cycle after handshake.
REQ-033 rst_n low during bit 4 -> all outputs 0 immediately; after release in_ready=1, fresh 0x01+0x01 -> 0x02.
REQ-034 Any operation -> exactly WIDTH single-cycle ISSUE pulses on fa_* matching operand bits and carry chain.
